// File: rtl/four_bank_mem_resp.sv
// four_bank_mem_resp: word memory responder with four independently busy banks (bank = addr[2:1]).
// Latency: read data with a one-cycle rd_valid pulse two cycles after accept; a bank is busy for three cycles after each accept.
// Backpressure: stall while the target bank is busy; err drops rd&wr, misaligned and (with FOUR_BANK_OOB_ERR_EN) out-of-range requests.
module four_bank_mem_resp #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd,
    input  logic              wr,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              stall,
    output logic [3:0]        busy,
    output logic              err
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [1:0]        bank;
    logic [IDX_W-1:0]  idx;
    logic              req;
    logic              oob;
    logic              accept;
    logic [1:0]        cnt [4];
    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    logic              v1;
    logic              v2;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;

    assign bank = addr[2:1];
    assign idx  = addr[IDX_W:1];
    assign req  = rd | wr;

    // Word-address bits above the storage index either flag out-of-range or are ignored (wrap).
    generate
        if (ADDR_W - 1 > IDX_W) begin : g_hi
            logic hi_nz;
            assign hi_nz = |addr[ADDR_W-1:IDX_W+1];
`ifdef FOUR_BANK_OOB_ERR_EN
            assign oob = hi_nz;
`else
            logic unused_hi;
            assign unused_hi = hi_nz;
            assign oob       = 1'b0;
`endif
        end else begin : g_nohi
            assign oob = 1'b0;
        end
    endgenerate

    assign err    = req & ((rd & wr) | addr[0] | oob);
    assign stall  = req & ~err & busy[bank];
    // Nothing is accepted in a reset cycle, so storage is not written then either.
    assign accept = req & ~err & ~busy[bank] & ~rst;

    always_comb begin
        busy = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            busy[b] = (cnt[b] != 2'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                cnt[b] <= 2'd0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (accept && (bank == 2'(b))) begin
                    cnt[b] <= 2'd3;
                end else if (cnt[b] != 2'd0) begin
                    cnt[b] <= cnt[b] - 2'd1;
                end
            end
        end
    end

    // Storage and its read register carry no reset so the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            mem[idx] <= data_in;
        end
        if (accept && rd) begin
            d1 <= mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            d2 <= '0;
        end else begin
            v1 <= accept & rd;
            v2 <= v1;
            if (v1) begin
                d2 <= d1;
            end
        end
    end

    assign rd_valid = v2;
    assign data_out = d2;

endmodule

// File: tb/tb_four_bank_mem_resp.sv
// Directed bench for four_bank_mem_resp: read results are scoreboarded by due cycle against a local word model.
module tb_four_bank_mem_resp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = '0;
    logic [15:0] data_in = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] data_out;
    logic        rd_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    typedef struct {
        int          cyc;
        logic [15:0] dat;
    } exp_t;

    exp_t        q[$];
    logic [15:0] mdl [1024];
    int          cyc = 0;
    int          checks = 0;
    int          passed = 0;

    four_bank_mem_resp dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .rd       (rd),
        .wr       (wr),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .stall    (stall),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One cycle: drive the request just after the edge, return at the following negedge.
    task automatic step(input logic rs, input logic r, input logic w,
                        input logic [15:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        rst = rs; rd = r; wr = w; addr = a; data_in = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic push_rd(input logic [15:0] a);
        exp_t e;
        e.cyc = cyc + 2;
        e.dat = mdl[a[10:1]];
        q.push_back(e);
    endtask

    task automatic wr_word(input logic [15:0] a, input logic [15:0] d);
        step(1'b0, 1'b0, 1'b1, a, d);
        chk("pre_stall", stall, 0);
        chk("pre_err", err, 0);
        mdl[a[10:1]] = d;
        idle(3);
    endtask

    // Scoreboard: each cycle either a read is due (must appear with the model data) or rd_valid must be low.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
            chk("rd_valid", rd_valid, 1);
            chk("data_out", data_out, q[0].dat);
            void'(q.pop_front());
        end else begin
            chk("rd_idle", rd_valid, 0);
        end
    end

    initial begin
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("rst_busy", busy, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_stall", stall, 0);
        chk("rst_err", err, 0);

        wr_word(16'h0008, 16'h1111);
        wr_word(16'h0048, 16'h2222);
        wr_word(16'h0020, 16'h3333);
        wr_word(16'h0030, 16'h1234);
        wr_word(16'h0042, 16'h5555);

        // write then read same address
        step(1'b0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
        chk("t1_wr_stall", stall, 0);
        mdl[16'h0010 >> 1] = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            chk("t1_busy", busy, 4'b0001);
        end
        step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        chk("t1_rd_stall", stall, 0);
        push_rd(16'h0010);
        idle(4);

        // same-bank conflict
        step(1'b0, 1'b1, 1'b0, 16'h0008, 16'h0000);
        chk("t2_first_stall", stall, 0);
        push_rd(16'h0008);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0048, 16'h0000);
            chk("t2_stall", stall, 1);
            chk("t2_err", err, 0);
        end
        step(1'b0, 1'b1, 1'b0, 16'h0048, 16'h0000);
        chk("t2_accept_stall", stall, 0);
        push_rd(16'h0048);
        idle(4);

        // four-bank streaming
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 16'(2 * i), 16'hA000 + 16'(2 * i));
            chk("t3_wr_stall", stall, 0);
            mdl[i] = 16'hA000 + 16'(2 * i);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'(2 * i), 16'h0000);
            chk("t3_rd_stall", stall, 0);
            push_rd(16'(2 * i));
        end
        idle(5);

        // illegal requests while bank 0 is busy
        step(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        chk("t4_pre_stall", stall, 0);
        push_rd(16'h0000);
        step(1'b0, 1'b1, 1'b1, 16'h0020, 16'hFFFF);
        chk("t4_rdwr_err", err, 1);
        chk("t4_rdwr_stall", stall, 0);
        chk("t4_rdwr_busy", busy, 4'b0001);
        step(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000);
        chk("t4_mis_err", err, 1);
        chk("t4_mis_stall", stall, 0);
        chk("t4_mis_busy", busy, 4'b0001);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("t4_busy_c3", busy, 4'b0001);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("t4_busy_c4", busy, 4'b0000);
        step(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
        chk("t4_rd20_stall", stall, 0);
        chk("t4_rd20_err", err, 0);
        push_rd(16'h0020);
        idle(4);

        // reset mid-read; a write presented in the reset cycle is dropped
        step(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000);
        chk("t5_rd_stall", stall, 0);
        step(1'b1, 1'b0, 1'b1, 16'h0042, 16'hDEAD);
        step(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000);
        chk("t5_busy", busy, 0);
        chk("t5_stall", stall, 0);
        chk("t5_rd_valid", rd_valid, 0);
        push_rd(16'h0030);
        idle(3);
        step(1'b0, 1'b1, 1'b0, 16'h0042, 16'h0000);
        chk("t5_rd42_stall", stall, 0);
        push_rd(16'h0042);
        idle(4);

        // out-of-range word address
        step(1'b0, 1'b1, 1'b0, 16'h0800, 16'h0000);
`ifdef FOUR_BANK_OOB_ERR_EN
        chk("t6_oob_err", err, 1);
        chk("t6_oob_stall", stall, 0);
`else
        chk("t6_wrap_err", err, 0);
        chk("t6_wrap_stall", stall, 0);
        push_rd(16'h0800);
`endif
        idle(4);

        chk("sb_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
